inv_test_sequencer: RTL and testbench

INV_TEST_SEQUENCER -- requirements
Module: inv_test_sequencer

---
 rtl/inv_test_sequencer_if.sv | 11 +
 rtl/inv_test_sequencer.sv | 146 ++++++++++++++
 tb/tb_inv_test_sequencer.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/inv_test_sequencer_if.sv
// Pin bundle between the inverter test sequencer and its surroundings.
interface inv_test_sequencer_if;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;
  logic [7:0] uo_out;

  modport master (output ui_in, output uio_in, input uio_out, input uio_oe, input uo_out);
  modport slave  (input ui_in, input uio_in, output uio_out, output uio_oe, output uo_out);
endinterface

// File: rtl/inv_test_sequencer.sv
// Drives LFSR stimulus into an external inverter, measures response latency per
// vector and reports error count, worst-case latency and pass/done status.
module inv_test_sequencer #(
  parameter int unsigned NUM_VEC = 32,
  parameter int unsigned TIMEOUT = 15,
  parameter logic [7:0]  SEED    = 8'hA5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ena,
  inv_test_sequencer_if.slave  bus
);

  localparam int unsigned CW = 5;
  localparam int unsigned VW = 8;
  localparam logic [CW-1:0] ERR_MAX = '1;
  localparam logic [CW-1:0] TO      = CW'(TIMEOUT);
  localparam logic [VW-1:0] LAST    = VW'(NUM_VEC - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_DRIVE,
    S_WAIT,
    S_NEXT,
    S_DONE
  } state_t;

  state_t          state;
  logic [7:0]      lfsr;
  logic [VW-1:0]   vec;
  logic [CW-1:0]   lat;
  logic [CW-1:0]   err;
  logic [CW-1:0]   maxlat;
  logic            drive;
  logic            busy;
  logic            done;
  logic            pass;
  logic            sync1;
  logic            obs;
  logic            start_q;
  logic            armed;
  logic            start_edge;
  logic            fb_c;
  logic            unused_bits;

  assign fb_c        = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];
  assign unused_bits = ^{bus.ui_in[7:3], bus.uio_in};

  // Two-flop synchronizer for the asynchronous inverter response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      obs   <= 1'b0;
    end else if (ena) begin
      sync1 <= bus.ui_in[1];
      obs   <= sync1;
    end
  end

  // Start edge only counts once a low level has been seen since reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_q    <= 1'b0;
      armed      <= 1'b0;
      start_edge <= 1'b0;
    end else if (ena) begin
      start_q    <= bus.ui_in[0];
      armed      <= armed | ~bus.ui_in[0];
      start_edge <= bus.ui_in[0] & ~start_q & armed;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      lfsr   <= '0;
      vec    <= '0;
      lat    <= '0;
      err    <= '0;
      maxlat <= '0;
      drive  <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      pass   <= 1'b0;
    end else if (ena) begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start_edge) begin
            state <= S_LOAD;
            busy  <= 1'b1;
            done  <= 1'b0;
            pass  <= 1'b0;
          end
        end
        S_LOAD: begin
          lfsr   <= SEED;
          vec    <= '0;
          err    <= '0;
          maxlat <= '0;
          state  <= S_DRIVE;
        end
        S_DRIVE: begin
          drive <= lfsr[0];
          lfsr  <= {lfsr[6:0], fb_c};
          lat   <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (obs == ~drive) begin
            if (lat > maxlat) maxlat <= lat;
            state <= S_NEXT;
          end else if (lat == TO) begin
            if (err != ERR_MAX) err <= err + CW'(1);
            if (TO > maxlat) maxlat <= TO;
            state <= S_NEXT;
          end else begin
            lat <= lat + CW'(1);
          end
        end
        S_NEXT: begin
          vec <= vec + VW'(1);
          if (vec == LAST) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err == '0);
          end else begin
            state <= S_DRIVE;
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
          pass  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.uio_out = {7'b0, drive};
  assign bus.uio_oe  = 8'h01;
  assign bus.uo_out  = {busy, done, pass, (bus.ui_in[2] ? maxlat : err)};

endmodule

// File: tb/tb_inv_test_sequencer.sv
// Self-checking bench: external inverter/buffer with programmable delay, per-run
// expectations from a vector-level latency model.
module tb_inv_test_sequencer;

  logic clk = 1'b0;
  logic rst_n;
  logic ena;
  always #5 clk = ~clk;

  inv_test_sequencer_if bus0();
  inv_test_sequencer_if bus1();

  logic        start0, sel0, start1, sel1;
  logic        env_buf;
  int          env_d;
  logic [15:0] pipe;
  logic        tap, env_obs;
  int          ncmp = 0;
  int          nfail = 0;
  bit          last0;

  // External device under characterisation: delayed inverter or buffer.
  always @(posedge clk) pipe <= {pipe[14:0], bus0.uio_out[0]};
  always_comb begin
    tap     = (env_d == 0) ? bus0.uio_out[0] : pipe[env_d-1];
    env_obs = env_buf ? tap : ~tap;
  end

  assign bus0.ui_in  = {5'b0, sel0, env_obs, start0};
  assign bus0.uio_in = 8'h00;
  assign bus1.ui_in  = {5'b0, sel1, bus1.uio_out[0], start1};
  assign bus1.uio_in = 8'h00;

  inv_test_sequencer dut0 (.clk(clk), .rst_n(rst_n), .ena(ena), .bus(bus0));
  inv_test_sequencer #(.NUM_VEC(80)) dut1 (.clk(clk), .rst_n(rst_n), .ena(ena), .bus(bus1));

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    ncmp++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Vector-level model: a changed drive bit needs the full round trip, an
  // unchanged one is already settled; a buffer only ever "matches" on a change.
  task automatic model_run(input int nvec, input bit buf_mode, input int d, input bit prev,
                           output int e, output int ml, output bit last);
    logic [7:0] r;
    bit p, b;
    r = 8'hA5; p = prev; e = 0; ml = 0;
    for (int v = 0; v < nvec; v++) begin
      b = r[0];
      r = {r[6:0], r[7] ^ r[5] ^ r[4] ^ r[3]};
      if (buf_mode) begin
        if (b == p) begin
          e  = (e < 31) ? e + 1 : 31;
          ml = (ml > 15) ? ml : 15;
        end
      end else if (b != p) begin
        ml = (ml > d + 2) ? ml : d + 2;
      end
      p = b;
    end
    last = p;
  endtask

  task automatic wait_done0(input string tag);
    int n = 0;
    while (!bus0.uo_out[6] && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_done"}, {7'b0, bus0.uo_out[6]}, 8'h01);
  endtask

  task automatic check_res0(input string tag, input int e, input int ml);
    sel0 = 1'b0; #1;
    check({tag, "_flags"}, {5'b0, bus0.uo_out[7:5]}, {5'b0, 2'b01, (e == 0)});
    check({tag, "_err"},   {3'b0, bus0.uo_out[4:0]}, 8'(e));
    sel0 = 1'b1; #1;
    check({tag, "_maxlat"}, {3'b0, bus0.uo_out[4:0]}, 8'(ml));
    sel0 = 1'b0;
  endtask

  task automatic pulse_start0();
    start0 = 1'b0;
    repeat (2) @(negedge clk);
    start0 = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic run0(input string tag, input bit buf_mode, input int d);
    int e, ml;
    env_buf = buf_mode; env_d = d;
    repeat (20) @(negedge clk);
    pulse_start0();
    check({tag, "_busy"}, {6'b0, bus0.uo_out[7:6]}, 8'h02);
    start0 = 1'b0;
    wait_done0(tag);
    model_run(32, buf_mode, d, last0, e, ml, last0);
    check_res0(tag, e, ml);
  endtask

  initial begin
    int e, ml, n;
    bit lst, rb;
    int rd;
    rst_n = 1'b0; ena = 1'b1; start0 = 1'b0; start1 = 1'b0; sel0 = 1'b0; sel1 = 1'b0;
    env_buf = 1'b0; env_d = 0; last0 = 1'b0;
    #1;
    check("rst_uo",     bus0.uo_out,  8'h00);
    check("rst_uio",    bus0.uio_out, 8'h00);
    check("rst_oe",     bus0.uio_oe,  8'h01);
    check("rst_uo_big", bus1.uo_out,  8'h00);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    run0("inv_d0", 1'b0, 0);
    run0("buf",    1'b1, 0);
    run0("inv_d5", 1'b0, 5);

    // Longer run with a buffer to push the error counter into saturation.
    start1 = 1'b1;
    repeat (2) @(negedge clk);
    start1 = 1'b0;
    n = 0;
    while (!bus1.uo_out[6] && n < 5000) begin
      @(negedge clk);
      n++;
    end
    model_run(80, 1'b1, 0, 1'b0, e, ml, lst);
    sel1 = 1'b0; #1;
    check("sat_flags", {5'b0, bus1.uo_out[7:5]}, {5'b0, 2'b01, (e == 0)});
    check("sat_err",   {3'b0, bus1.uo_out[4:0]}, 8'(e));
    sel1 = 1'b1; #1;
    check("sat_maxlat", {3'b0, bus1.uo_out[4:0]}, 8'(ml));

    for (int i = 0; i < 4; i++) begin
      rb = 1'($urandom_range(0, 1));
      rd = rb ? 0 : int'($urandom_range(0, 10));
      run0($sformatf("rand%0d", i), rb, rd);
    end

    // Reset in the middle of a run.
    env_buf = 1'b0; env_d = 0;
    repeat (20) @(negedge clk);
    pulse_start0();
    start0 = 1'b0;
    repeat (40) @(negedge clk);
    check("mid_busy", {7'b0, bus0.uo_out[7]}, 8'h01);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_uo",  bus0.uo_out,  8'h00);
    check("mid_rst_uio", bus0.uio_out, 8'h00);
    check("mid_rst_oe",  bus0.uio_oe,  8'h01);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    last0 = 1'b0;
    run0("post_rst", 1'b0, 0);

    // Start held high across reset release must not launch a run.
    start0 = 1'b1;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    last0 = 1'b0;
    env_buf = 1'b1; env_d = 0;
    repeat (20) @(negedge clk);
    check("held_idle", {6'b0, bus0.uo_out[7:6]}, 8'h00);
    start0 = 1'b0;
    repeat (2) @(negedge clk);
    start0 = 1'b1;
    repeat (2) @(negedge clk);
    check("held_busy", {6'b0, bus0.uo_out[7:6]}, 8'h02);
    wait_done0("held");
    model_run(32, 1'b1, 0, last0, e, ml, last0);
    check_res0("held", e, ml);
    repeat (100) @(negedge clk);
    check("held_once", {5'b0, bus0.uo_out[7:5]}, {5'b0, 2'b01, (e == 0)});

    // Clock enable low freezes everything, including edge detection.
    ena = 1'b0;
    start0 = 1'b0;
    repeat (3) @(negedge clk);
    start0 = 1'b1;
    repeat (3) @(negedge clk);
    check("ena_hold", {5'b0, bus0.uo_out[7:5]}, {5'b0, 2'b01, (e == 0)});
    ena = 1'b1;
    repeat (5) @(negedge clk);
    check("ena_noedge", {5'b0, bus0.uo_out[7:5]}, {5'b0, 2'b01, (e == 0)});

    // Restart from DONE: busy two cycles after the edge, counters cleared.
    start0 = 1'b0;
    repeat (2) @(negedge clk);
    start0 = 1'b1;
    @(negedge clk);
    check("rs_c1", {6'b0, bus0.uo_out[7:6]}, 8'h01);
    @(negedge clk);
    check("rs_c2", {6'b0, bus0.uo_out[7:6]}, 8'h02);
    @(negedge clk);
    sel0 = 1'b0; #1;
    check("rs_err0", {3'b0, bus0.uo_out[4:0]}, 8'h00);
    sel0 = 1'b1; #1;
    check("rs_maxlat0", {3'b0, bus0.uo_out[4:0]}, 8'h00);
    sel0 = 1'b0;
    wait_done0("restart");
    model_run(32, 1'b1, 0, last0, e, ml, last0);
    check_res0("restart", e, ml);
    check("end_oe", bus0.uio_oe, 8'h01);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
